// File: rtl/cordic_polar_rect_iter.sv
// Iterative CORDIC rotation: polar (mag, theta) to rectangular (x, y), one micro-rotation per
// clock, with valid/ready handshakes on both sides.
module cordic_polar_rect_iter #(
    parameter int unsigned ITERS  = 14,
    parameter int unsigned GAIN_K = 19899
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mag_in,
    input  logic [15:0] theta_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StPre, StIter, StDone} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic        [14:0] r_mag;
    logic        [15:0] r_theta;
    logic signed [17:0] r_x;
    logic signed [17:0] r_y;
    logic signed [17:0] r_z;
    logic         [3:0] r_iter;
    logic        [15:0] r_x_out;
    logic        [15:0] r_y_out;

    logic        [31:0] w_prod;
    logic signed [17:0] w_x0;
    logic signed [17:0] w_fx;
    logic signed [17:0] w_fy;
    logic signed [17:0] w_fz;
    logic        [15:0] w_z16;
    logic signed [17:0] w_xs;
    logic signed [17:0] w_ys;
    logic signed [17:0] w_atan;
    logic signed [17:0] w_xn;
    logic signed [17:0] w_yn;
    logic signed [17:0] w_zn;
    logic               w_last;

    localparam logic signed [17:0] SatMax = 18'sd32767;
    localparam logic signed [17:0] SatMin = -18'sd32768;

    // atan(2^-i) in binary-angle units (2*pi == 65536)
    function automatic logic signed [17:0] atan_rom(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_rom = 18'sd8192;
            4'd1:    atan_rom = 18'sd4836;
            4'd2:    atan_rom = 18'sd2555;
            4'd3:    atan_rom = 18'sd1297;
            4'd4:    atan_rom = 18'sd651;
            4'd5:    atan_rom = 18'sd326;
            4'd6:    atan_rom = 18'sd163;
            4'd7:    atan_rom = 18'sd81;
            4'd8:    atan_rom = 18'sd41;
            4'd9:    atan_rom = 18'sd20;
            4'd10:   atan_rom = 18'sd10;
            4'd11:   atan_rom = 18'sd5;
            4'd12:   atan_rom = 18'sd3;
            4'd13:   atan_rom = 18'sd1;
            4'd14:   atan_rom = 18'sd1;
            default: atan_rom = 18'sd0;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input logic signed [17:0] v);
        if (v > SatMax) begin
            sat16 = 16'h7FFF;
        end else if (v < SatMin) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    // Gain pre-scale and quadrant fold so the residual angle fits the CORDIC convergence range
    always_comb begin
        w_prod = 32'(r_mag) * GAIN_K;
        w_x0   = $signed({1'b0, w_prod[31:15]});
        w_fx   = w_x0;
        w_fy   = '0;
        w_z16  = r_theta;
        case (r_theta[15:14])
            2'b01: begin
                w_fx  = '0;
                w_fy  = w_x0;
                w_z16 = r_theta - 16'h4000;
            end
            2'b10: begin
                w_fx  = '0;
                w_fy  = -w_x0;
                w_z16 = r_theta + 16'h4000;
            end
            default: ;
        endcase
        w_fz = {{2{w_z16[15]}}, w_z16};
    end

    always_comb begin
        w_xs   = r_x >>> r_iter;
        w_ys   = r_y >>> r_iter;
        w_atan = atan_rom(r_iter);
        if (r_z[17]) begin
            w_xn = r_x + w_ys;
            w_yn = r_y - w_xs;
            w_zn = r_z + w_atan;
        end else begin
            w_xn = r_x - w_ys;
            w_yn = r_y + w_xs;
            w_zn = r_z - w_atan;
        end
        w_last = (r_iter == 4'(ITERS - 1));
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (in_valid) w_state_d = StPre;
            StPre:   w_state_d = StIter;
            StIter:  if (w_last) w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        busy      = (r_state != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag   <= '0;
            r_theta <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_mag   <= mag_in[15] ? 15'd0 : mag_in[14:0];
                        r_theta <= theta_in;
                    end
                end
                StPre: begin
                    r_x    <= w_fx;
                    r_y    <= w_fy;
                    r_z    <= w_fz;
                    r_iter <= '0;
                end
                StIter: begin
                    r_x    <= w_xn;
                    r_y    <= w_yn;
                    r_z    <= w_zn;
                    r_iter <= r_iter + 4'd1;
                    if (w_last) begin
                        r_x_out <= sat16(w_xn);
                        r_y_out <= sat16(w_yn);
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out = r_x_out;
    assign y_out = r_y_out;

endmodule

// File: tb/tb_cordic_polar_rect_iter.sv
// Scoreboard bench for cordic_polar_rect_iter: trig reference model, decoupled accept and
// output monitors, directed plan cases plus randomized samples under random backpressure.
module tb_cordic_polar_rect_iter;

    localparam int  ITERS = 14;
    localparam real PI    = 3.14159265358979;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] mag_in   = '0;
    logic [15:0] theta_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic        busy;

    logic or_main = 1'b1;
    logic bp_rand = 1'b1;
    logic rnd_bp  = 1'b0;
    assign out_ready = rnd_bp ? bp_rand : or_main;

    cordic_polar_rect_iter #(
        .ITERS (ITERS),
        .GAIN_K(19899)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mag_in   (mag_in),
        .theta_in (theta_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .y_out    (y_out),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    bit strict   = 1'b1;

    typedef struct {
        int ex_x;
        int ex_y;
        int tol;
        int acc_cyc;
    } exp_t;
    exp_t sb_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int round_r(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic check(input string name, input int act, input int req, input int tol);
        n_checks++;
        if (act > req + tol || act < req - tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (+/-%0d) at cycle %0d",
                     name, act, req, tol, cyc);
        end
    endtask

    // Accept monitor: every handshake pushes the ideal trig result into the scoreboard.
    initial begin
        int  m;
        real a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) begin
                m = mag_in[15] ? 0 : int'(mag_in);
                a = real'(theta_in) * 2.0 * PI / 65536.0;
                e.ex_x = round_r(real'(m) * $cos(a));
                e.ex_y = round_r(real'(m) * $sin(a));
                // Random samples allow for ROM rounding in the residual angle at large magnitudes
                if (m == 0) e.tol = 0;
                else if (strict) e.tol = 4;
                else e.tol = 4 + $rtoi($ceil(real'(m) * 3.0 * 2.0 * PI / 65536.0));
                e.acc_cyc = cyc;
                sb_q.push_back(e);
                n_acc++;
            end
        end
    end

    // Output monitor: tracks stability while held, compares on each output handshake.
    initial begin
        int   ov_x, ov_y, ov_cyc;
        bit   prev_v, stable, hold_ok, post_hs;
        exp_t e;
        prev_v  = 1'b0;
        post_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v  = 1'b0;
                post_hs = 1'b0;
            end else begin
                if (post_hs) begin
                    post_hs = 1'b0;
                    check("post_hs_out_valid", int'(out_valid), 0, 0);
                    check("post_hs_in_ready", int'(in_ready), 1, 0);
                end
                if (out_valid) begin
                    if (!prev_v) begin
                        ov_x    = int'($signed(x_out));
                        ov_y    = int'($signed(y_out));
                        ov_cyc  = cyc;
                        stable  = 1'b1;
                        hold_ok = 1'b1;
                    end else if (int'($signed(x_out)) != ov_x || int'($signed(y_out)) != ov_y) begin
                        stable = 1'b0;
                    end
                    if (in_ready || !busy) hold_ok = 1'b0;
                    if (out_ready) begin
                        check("out_has_pending_sample", int'(sb_q.size() > 0), 1, 0);
                        if (sb_q.size() > 0) begin
                            e = sb_q.pop_front();
                            check("x_out", int'($signed(x_out)), e.ex_x, e.tol);
                            check("y_out", int'($signed(y_out)), e.ex_y, e.tol);
                            check("latency", ov_cyc - e.acc_cyc, ITERS + 2, 0);
                            check("held_stable", int'(stable), 1, 0);
                            check("busy_not_ready_in_done", int'(hold_ok), 1, 0);
                        end
                        post_hs = 1'b1;
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the sample.
    task automatic send(input logic [15:0] m, input logic [15:0] t, input bit keep_valid,
                        output int acc_cyc);
        in_valid = 1'b1;
        mag_in   = m;
        theta_in = t;
        acc_cyc  = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) check("accept_timeout", 0, 1, 0);
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", sb_q.size(), 0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2, acc_before;
        bit seen;
        logic [15:0] bt [7];
        logic [15:0] rm;

        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_x_out", int'(x_out), 0, 0);
        check("rst_y_out", int'(y_out), 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Quadrant and diagonal cases
        strict = 1'b1;
        send(16'd16384, 16'h0000, 1'b0, a0);
        send(16'd16384, 16'h4000, 1'b0, a0);
        send(16'd16384, 16'h8000, 1'b0, a0);
        send(16'd16384, 16'hC000, 1'b0, a0);
        send(16'd32767, 16'h2000, 1'b0, a0);
        wait_drain();

        // Backpressure: result must hold while out_ready is low; extra in_valid ignored
        or_main = 1'b0;
        send(16'd12000, 16'h4000, 1'b0, a0);
        acc_before = n_acc;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", int'(seen), 1, 0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        mag_in   = 16'd5000;
        theta_in = 16'h1234;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_second_sample_ignored", n_acc, acc_before, 0);
        check("bp_in_ready_low", int'(in_ready), 0, 0);
        check("bp_out_valid_held", int'(out_valid), 1, 0);
        @(posedge clk);
        #1;
        or_main = 1'b1;
        wait_drain();

        // Asynchronous reset during iteration 5 discards the sample
        send(16'd20000, 16'h2345, 1'b0, a0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cyc == a0 + 7) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_iter_reached", int'(seen), 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0, 0);
        check("arst_x_out", int'(x_out), 0, 0);
        check("arst_y_out", int'(y_out), 0, 0);
        check("arst_in_ready", int'(in_ready), 1, 0);
        check("arst_busy", int'(busy), 0, 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'd1000, 16'h1555, 1'b0, a0);
        wait_drain();

        // Back-to-back with negative magnitude first
        send(16'h8000, 16'h1000, 1'b1, a0);
        send(16'd1000, 16'h1555, 1'b1, a1);
        send(16'd16384, 16'h0000, 1'b0, a2);
        check("b2b_spacing_1", a1 - a0, ITERS + 3, 0);
        check("b2b_spacing_2", a2 - a1, ITERS + 3, 0);
        wait_drain();

        // Random samples under random backpressure, then full-scale quadrant edges
        strict = 1'b0;
        rnd_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bp_rand = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) rm = 16'h8000 | 16'($urandom);
            else rm = 16'($urandom_range(0, 32767));
            send(rm, 16'($urandom), 1'b0, a0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                bp_rand = ($urandom_range(0, 3) != 0);
            end
        end
        bt = '{16'h3FFF, 16'h4001, 16'h7FFF, 16'h8001, 16'hBFFF, 16'hC001, 16'hFFFF};
        for (int n = 0; n < 7; n++) begin
            bp_rand = ($urandom_range(0, 1) != 0);
            send(16'd32767, bt[n], 1'b0, a0);
        end
        rnd_bp = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Random backpressure pattern generator while rnd_bp is set
    initial forever begin
        @(posedge clk);
        #2;
        if (rnd_bp) bp_rand = ($urandom_range(0, 3) != 0);
    end

endmodule

// File: doc/cordic_polar_rect_iter.md
Name: cordic_polar_rect_iter

Overview:
- Iterative, handshaked CORDIC rotation engine: converts a polar velocity sample (magnitude, angle) into rectangular components (x, y).
- Sits directly upstream of the velocity-selection stage and supplies its x/y rotated velocity inputs.
- Resolves one CORDIC micro-rotation per clock.
- Uses a valid/ready handshake so upstream samplers and downstream consumers can stall it.

Parameters:
- ITERS, 14, number of micro-rotations. Legal range 8..16.
- GAIN_K, 19899, CORDIC gain compensation 1/K in Q1.15 (0.607253*32768, rounded).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  mag_in/theta_in valid.
- in_ready  output  1  block can accept a sample.
- mag_in  input  16  magnitude, signed, must be >= 0 (0..32767). Negative values are treated as 0.
- theta_in  input  16  binary angle. Full scale 2π; 0x0000 = 0, 0x4000 = +π/2, 0x8000 = -π, 0xC000 = -π/2.
- out_valid  output  1  x_out/y_out valid.
- out_ready  input  1  consumer accepts result.
- x_out  output  16  mag*cos(theta), signed two's complement.
- y_out  output  16  mag*sin(theta), signed two's complement.
- busy  output  1  high in PRE, ITER, DONE.

Behaviour:

Reset (asynchronous, rst_n low):
- state=IDLE, in_ready=1, out_valid=0, busy=0, x_out=0, y_out=0, iteration counter=0.
- Takes effect immediately, including mid-iteration; an in-flight sample is discarded with no output.

FSM:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture mag_in (negatives clamped to 0) and theta_in -> PRE.
- PRE (1 cycle):
  - Gain pre-scale: x0 = (mag*GAIN_K)>>>15, y0 = 0. Internal datapath is 18-bit signed, with 2 guard bits.
  - Quadrant fold on theta[15:14]:
    - 00 or 11: no change.
    - 01: (x,y) = (0, x0), z = theta - 0x4000.
    - 10: (x,y) = (0, -x0), z = theta + 0x4000 (wraps mod 2^16).
  - Residual z then lies in [-0x4000, +0x4000].
  - Next state: ITER, i=0.
- ITER (exactly ITERS cycles, i = 0..ITERS-1):
  - d = (z >= 0) ? +1 : -1.
  - x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i].
  - Shifts are arithmetic.
  - After i = ITERS-1 -> DONE.
- ATAN ROM (binary-angle units), i = 0..15:
  - 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- DONE:
  - x_out/y_out = x/y saturated to [-32768, 32767], registered on entry; out_valid=1.
  - Held stable until out_valid&&out_ready.
  - On handshake: out_valid=0, go to IDLE (in_ready=1 the following cycle). No same-cycle re-accept.

Timing and handshake rules:
- Latency: accept at cycle T gives out_valid at T+ITERS+2.
- Throughput: one sample per ITERS+3 cycles when out_ready is held high.
- in_ready=0 in PRE, ITER and DONE. in_valid while not ready is ignored, not queued.
- out_ready low indefinitely: outputs hold, no state change.
- out_ready is ignored when out_valid=0.

Accuracy:
- |error| <= 4 LSB per component for ITERS=14 and mag <= 32767.
- mag=0 -> outputs exactly 0.

Test Plan:
- mag=16384, theta=0x0000 -> out_valid at accept+16. x_out=16384±4, y_out=0±4.
- mag=16384, theta=0x4000 -> x_out=0±4, y_out=16384±4. Then theta=0x8000 -> x_out=-16384±4, y_out=0±4. Then theta=0xC000 -> y_out=-16384±4.
- mag=32767, theta=0x2000 (π/4) -> x_out=y_out=23170±4. No saturation flag: outputs stay within range.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> x/y stable, in_ready=0, a second in_valid pulse is ignored. Release -> out_valid drops next cycle, in_ready=1 one cycle later, next sample accepted.
- Reset mid-ITER (rst_n low at iteration 5) -> out_valid=0, x_out=y_out=0, in_ready=1 asynchronously. After release, a fresh sample (mag=1000, theta=0x1555) gives x_out=866±4, y_out=500±4.
- mag_in=0x8000 (negative) with theta=0x1000 -> x_out=y_out=0. Back-to-back samples with continuous in_valid/out_ready -> accept spacing exactly ITERS+3 cycles.
